// File: rtl/fp_pkg.sv
// Shared types and constants for the FP adder normalize/round back end.
package fp_pkg;

  localparam int EXP_W   = 8;
  localparam int FRAC_W  = 23;
  localparam int EXT_W   = 8;
  localparam int BIAS    = 127;
  localparam int EXP_MAX = 255;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exponent;
    logic [FRAC_W-1:0] fraction;
  } fp32_t;

  typedef enum logic [1:0] {IDLE, NORM, ROUND, OUT} norm_state_t;

endpackage

// File: rtl/lzc_limit.sv
// Leading-zero count of a 32-bit mantissa, saturated at SHIFT_STEP.
// Only the top SHIFT_STEP bits are inspected, which keeps the priority chain short.
module lzc_limit #(
  parameter int SHIFT_STEP = 1
) (
  input  logic [31:0] mant,
  output logic [3:0]  count
);

  logic found;

  // Scan from the MSB down; the first set bit gives the count, else saturate.
  always_comb begin
    count = 4'(SHIFT_STEP);
    found = 1'b0;
    for (int i = 0; i < SHIFT_STEP; i++) begin
      if (!found && mant[31-i]) begin
        count = 4'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp_normalize_round.sv
// Renormalizes an aligned signed-magnitude mantissa sum, rounds to nearest-even
// and packs a binary32 result with overflow/underflow/inexact flags.
// One operation in flight: IDLE -> NORM (1+ cycles) -> ROUND -> OUT.
module fp_normalize_round
  import fp_pkg::*;
#(
  parameter int SHIFT_STEP = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        signIn,
  input  logic [7:0]  exponentIn,
  input  logic [32:0] mantissaIn,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        overflow,
  output logic        underflow,
  output logic        inexact
);

  norm_state_t state_q, state_d;
  logic [32:0] mant_q, mant_d;
  logic [9:0]  exp_q, exp_d;
  logic        sign_q, sign_d;
  logic        sticky_q, sticky_d;
  logic        zero_q, zero_d;
  logic        out_valid_q, out_valid_d;
  fp32_t       result_q, result_d;
  logic        overflow_q, overflow_d;
  logic        underflow_q, underflow_d;
  logic        inexact_q, inexact_d;

  // Left-shift amount limited by SHIFT_STEP, leading zeros and exponent headroom.
  logic [3:0]  lz;
  logic [3:0]  k;
  logic [9:0]  exp_room;

  lzc_limit #(.SHIFT_STEP(SHIFT_STEP)) u_lzc (
    .mant  (mant_q[31:0]),
    .count (lz)
  );

  // Shift limit: never drop the exponent below 1 (subnormal floor).
  always_comb begin
    exp_room = exp_q - 10'd1;
    k        = (exp_room < 10'(lz)) ? exp_room[3:0] : lz;
  end

  // Round-to-nearest-even on the 24-bit significand plus guard/sticky.
  logic        guard, st, lsb, up;
  logic [24:0] sig_raw, sig;
  logic [9:0]  exp_r;
  logic [7:0]  field;
  logic        rnd_inexact;

  always_comb begin
    guard       = mant_q[EXT_W-1];
    st          = sticky_q | (|mant_q[EXT_W-2:0]);
    lsb         = mant_q[EXT_W];
    up          = guard & (st | lsb);
    rnd_inexact = guard | st;
    sig_raw     = {1'b0, mant_q[31:EXT_W]} + 25'(up);
    sig         = sig_raw;
    exp_r       = exp_q;
    if (sig_raw[24]) begin
      sig   = sig_raw >> 1;
      exp_r = exp_q + 10'd1;
    end
    // A subnormal whose rounding carries into bit 23 picks up field 1 via exp_r==1.
    field = sig[23] ? exp_r[7:0] : 8'd0;
  end

  // Next-state and datapath update for the normalize/round sequence.
  always_comb begin
    state_d     = state_q;
    mant_d      = mant_q;
    exp_d       = exp_q;
    sign_d      = sign_q;
    sticky_d    = sticky_q;
    zero_d      = zero_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    inexact_d   = inexact_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          mant_d   = mantissaIn;
          sign_d   = signIn;
          sticky_d = 1'b0;
          zero_d   = 1'b0;
          exp_d    = (exponentIn == 8'd0) ? 10'd1 : {2'b00, exponentIn};
          state_d  = NORM;
        end
      end
      NORM: begin
        if (mant_q == 33'd0) begin
          zero_d  = 1'b1;
          state_d = ROUND;
        end else if (mant_q[32]) begin
          mant_d   = mant_q >> 1;
          sticky_d = sticky_q | mant_q[0];
          exp_d    = exp_q + 10'd1;
          state_d  = ROUND;
        end else if (mant_q[31] || exp_q == 10'd1) begin
          state_d = ROUND;
        end else begin
          mant_d = mant_q << k;
          exp_d  = exp_q - 10'(k);
        end
      end
      ROUND: begin
        out_valid_d = 1'b1;
        state_d     = OUT;
        if (zero_q) begin
          result_d    = '{sign: sign_q, exponent: '0, fraction: '0};
          overflow_d  = 1'b0;
          underflow_d = 1'b0;
          inexact_d   = 1'b0;
        end else if (exp_r >= 10'(EXP_MAX)) begin
          result_d    = '{sign: sign_q, exponent: '1, fraction: '0};
          overflow_d  = 1'b1;
          underflow_d = 1'b0;
          inexact_d   = rnd_inexact;
        end else begin
          result_d    = '{sign: sign_q, exponent: field, fraction: sig[FRAC_W-1:0]};
          overflow_d  = 1'b0;
          underflow_d = (field == 8'd0) & rnd_inexact;
          inexact_d   = rnd_inexact;
        end
      end
      OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset discards any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mant_q      <= '0;
      exp_q       <= '0;
      sign_q      <= 1'b0;
      sticky_q    <= 1'b0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      inexact_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mant_q      <= mant_d;
      exp_q       <= exp_d;
      sign_q      <= sign_d;
      sticky_q    <= sticky_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      inexact_q   <= inexact_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
  assign inexact   = inexact_q;

endmodule

// File: tb/tb_fp_normalize_round.sv
// Directed test of fp_normalize_round with SHIFT_STEP=1 (dut a) and 8 (dut b)
// sharing one input stream.
module tb_fp_normalize_round;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        signIn = 1'b0;
  logic [7:0]  exponentIn = '0;
  logic [32:0] mantissaIn = '0;
  logic        out_ready = 1'b0;

  logic        in_ready_a, out_valid_a, ovf_a, unf_a, inx_a;
  logic        in_ready_b, out_valid_b, ovf_b, unf_b, inx_b;
  logic [31:0] result_a, result_b;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fp_normalize_round #(.SHIFT_STEP(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
    .signIn(signIn), .exponentIn(exponentIn), .mantissaIn(mantissaIn),
    .out_valid(out_valid_a), .out_ready(out_ready), .result(result_a),
    .overflow(ovf_a), .underflow(unf_a), .inexact(inx_a)
  );

  fp_normalize_round #(.SHIFT_STEP(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
    .signIn(signIn), .exponentIn(exponentIn), .mantissaIn(mantissaIn),
    .out_valid(out_valid_b), .out_ready(out_ready), .result(result_b),
    .overflow(ovf_b), .underflow(unf_b), .inexact(inx_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // flags packed as {overflow, underflow, inexact}
  task automatic run_op(input string tag, input logic s, input logic [7:0] e,
                        input logic [32:0] m, input int lat_a_exp, input int lat_b_exp,
                        input logic [31:0] res_exp, input logic [2:0] flg_exp,
                        input int hold_cycles);
    int lat_a, lat_b;
    logic [31:0] held;
    @(negedge clk);
    chk({tag, " in_ready_a"}, 32'(in_ready_a), 32'd1);
    chk({tag, " in_ready_b"}, 32'(in_ready_b), 32'd1);
    signIn = s; exponentIn = e; mantissaIn = m; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat_a = 0;
    lat_b = 0;
    for (int c = 1; c <= 40 && (lat_a == 0 || lat_b == 0); c++) begin
      @(posedge clk);
      #1;
      if (out_valid_a && lat_a == 0) lat_a = c;
      if (out_valid_b && lat_b == 0) lat_b = c;
    end
    chk({tag, " latency_a"}, 32'(lat_a), 32'(lat_a_exp));
    chk({tag, " latency_b"}, 32'(lat_b), 32'(lat_b_exp));
    chk({tag, " result_a"}, result_a, res_exp);
    chk({tag, " result_b"}, result_b, res_exp);
    chk({tag, " flags_a"}, 32'({ovf_a, unf_a, inx_a}), 32'(flg_exp));
    chk({tag, " flags_b"}, 32'({ovf_b, unf_b, inx_b}), 32'(flg_exp));
    held = result_a;
    for (int h = 0; h < hold_cycles; h++) begin
      @(posedge clk);
      #1;
      chk({tag, " hold_result"}, result_a, held);
      chk({tag, " hold_valid"}, 32'(out_valid_a), 32'd1);
      chk({tag, " hold_in_ready"}, 32'(in_ready_a), 32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk({tag, " drained_a"}, 32'(out_valid_a), 32'd0);
    chk({tag, " drained_b"}, 32'(out_valid_b), 32'd0);
  endtask

  initial begin
    // reset state
    #2;
    chk("rst out_valid", 32'(out_valid_a), 32'd0);
    chk("rst result", result_a, 32'h0);
    chk("rst flags", 32'({ovf_a, unf_a, inx_a}), 32'd0);
    chk("rst in_ready", 32'(in_ready_a), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // 1.0 + 1.0 carry case
    run_op("one_plus_one", 1'b0, 8'h7F, 33'h1_0000_0000, 2, 2, 32'h40000000, 3'b000, 0);
    // cancellation: 8 single-step shifts vs one 8-step shift
    run_op("cancel", 1'b0, 8'h80, 33'h0_0080_0000, 10, 3, 32'h3C000000, 3'b000, 0);
    // tie with even lsb stays, tie with odd lsb rounds up
    run_op("tie_even", 1'b0, 8'h7F, 33'h0_8000_0080, 2, 2, 32'h3F800000, 3'b001, 0);
    run_op("tie_odd", 1'b0, 8'h7F, 33'h0_8000_0180, 2, 2, 32'h3F800002, 3'b001, 0);
    // overflow to infinity after carry and round-up
    run_op("overflow", 1'b0, 8'hFE, 33'h1_FFFF_FF80, 2, 2, 32'h7F800000, 3'b101, 0);
    // exact subnormal, inexact subnormal, signed zero
    run_op("subnorm_exact", 1'b0, 8'h01, 33'h0_4000_0000, 2, 2, 32'h00400000, 3'b000, 0);
    run_op("subnorm_round", 1'b0, 8'h00, 33'h0_0000_0180, 2, 2, 32'h00000002, 3'b011, 0);
    run_op("neg_zero", 1'b1, 8'h40, 33'h0, 2, 2, 32'h80000000, 3'b000, 0);
    // backpressure: result held for 5 cycles with out_ready low
    run_op("backpressure", 1'b1, 8'h7F, 33'h1_0000_0000, 2, 2, 32'hC0000000, 3'b000, 5);

    // asynchronous reset in the middle of a long normalization
    @(negedge clk);
    signIn = 1'b0; exponentIn = 8'h80; mantissaIn = 33'h0_0080_0000; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("mid_norm busy", 32'(in_ready_a), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst out_valid", 32'(out_valid_a), 32'd0);
    chk("mid_rst in_ready_a", 32'(in_ready_a), 32'd1);
    chk("mid_rst in_ready_b", 32'(in_ready_b), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("after_reset", 1'b0, 8'h7F, 33'h1_0000_0000, 2, 2, 32'h40000000, 3'b000, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // Overall time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
